// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice: FSM encoding, grant owner
// codes and bus widths. Build option: PARITY_EN adds the parity helper.
package mem_resp_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_A    = 2'd1;
  localparam logic [1:0] ID_B    = 2'd2;
  localparam logic [1:0] ID_C    = 2'd3;

`ifdef PARITY_EN
  // Even parity: the stored bit makes the 9-bit word carry an even count of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: 4096-deep synchronous single-port RAM. Write has priority over
// read; read data appears one cycle after re and holds until the next read.
// Contents are deliberately not reset.
module mem_array #(
  parameter int ADDR_W = 12,
  parameter int DW     = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DW-1:0] r_rdata;

  // Single port: write commits, otherwise a requested read is registered.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: shared memory target serving three bus masters (A/B/C).
// An accepted access is held for WAIT_STATES cycles, then completes in DONE
// with a one-cycle strobe to the owning master.
// Build option: define PARITY_EN to store even parity per byte and add perr.
//
//   state | meaning
//   IDLE  | ready; accepts sel with a non-zero grant_id
//   WAIT  | counting WAIT_STATES cycles, inputs ignored
//   DONE  | commit write / deliver read, strobes rise on the leaving edge
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  logic [1:0]        grant_id,
  input  logic              r_wb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_c,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic              rvalid_c,
  output logic              wdone,
  output logic              busy
`ifdef PARITY_EN
  ,output logic             perr
`endif
);

`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Last counter value before leaving WAIT; unused when WAIT is skipped.
  localparam logic [3:0] LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rwb;
  logic [1:0]        r_gid;

  logic              w_accept;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [MEM_W-1:0]  w_ram_wdata;
  logic [MEM_W-1:0]  w_ram_rdata;
  logic              w_rd_a;
  logic              w_rd_b;
  logic              w_rd_c;
  logic              w_wr_done;

  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic [DATA_W-1:0] r_rdata_c;
  logic              r_rvalid_a;
  logic              r_rvalid_b;
  logic              r_rvalid_c;
  logic              r_wdone;

  assign w_accept = (r_state == IDLE) && sel && (grant_id != ID_NONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and the per-cycle memory/strobe controls.
  always_comb begin
    w_next    = r_state;
    w_ram_we  = 1'b0;
    w_ram_re  = 1'b0;
    w_rd_a    = 1'b0;
    w_rd_b    = 1'b0;
    w_rd_c    = 1'b0;
    w_wr_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          // The RAM is read at the accept edge so data is ready by DONE.
          w_ram_re = r_wb;
          w_next   = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (r_count == LAST_CNT) w_next = DONE;
      end
      DONE: begin
        w_next    = IDLE;
        w_ram_we  = ~r_rwb;
        w_wr_done = ~r_rwb;
        w_rd_a    = r_rwb && (r_gid == ID_A);
        w_rd_b    = r_rwb && (r_gid == ID_B);
        w_rd_c    = r_rwb && (r_gid == ID_C);
      end
      default: w_next = IDLE;
    endcase
  end

  // Wait counter: held at zero outside WAIT, so it is clear on every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                r_count <= 4'd0;
    else if (r_state != WAIT) r_count <= 4'd0;
    else                      r_count <= r_count + 4'd1;
  end

  // Capture the access on the accept edge; later input changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rwb   <= 1'b0;
      r_gid   <= ID_NONE;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_rwb   <= r_wb;
      r_gid   <= grant_id;
    end
  end

  assign w_ram_addr = (r_state == IDLE) ? addr : r_addr;

`ifdef PARITY_EN
  assign w_ram_wdata = {even_parity(r_wdata), r_wdata};
`else
  assign w_ram_wdata = r_wdata;
`endif

  mem_array #(
    .ADDR_W (ADDR_W),
    .DW     (MEM_W)
  ) u_mem_array (
    .clock (clock),
    .we    (w_ram_we),
    .re    (w_ram_re),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // Completion strobes and per-master read data, registered on the DONE edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rvalid_c <= 1'b0;
      r_wdone    <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rdata_c  <= '0;
    end else begin
      r_rvalid_a <= w_rd_a;
      r_rvalid_b <= w_rd_b;
      r_rvalid_c <= w_rd_c;
      r_wdone    <= w_wr_done;
      if (w_rd_a) r_rdata_a <= w_ram_rdata[DATA_W-1:0];
      if (w_rd_b) r_rdata_b <= w_ram_rdata[DATA_W-1:0];
      if (w_rd_c) r_rdata_c <= w_ram_rdata[DATA_W-1:0];
    end
  end

`ifdef PARITY_EN
  logic r_perr;

  // Parity error flagged alongside the rvalid of the failing read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_perr <= 1'b0;
    else       r_perr <= (w_rd_a || w_rd_b || w_rd_c) && (^w_ram_rdata);
  end

  assign perr = r_perr;
`endif

  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign rdata_c  = r_rdata_c;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rvalid_c = r_rvalid_c;
  assign wdone    = r_wdone;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=0 at index 0,
// WAIT_STATES=2 at index 1) checked against a byte-array reference model.
module tb_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        in_sel   [2];
  logic [1:0]  in_gid   [2];
  logic        in_rwb   [2];
  logic [11:0] in_addr  [2];
  logic [7:0]  in_wdata [2];
  logic [7:0]  o_rd     [2][3];
  logic        o_rv     [2][3];
  logic        o_wdone  [2];
  logic        o_busy   [2];

  mem_responder #(.WAIT_STATES(0)) u_dut_ws0 (
    .clock(clock), .reset(reset), .sel(in_sel[0]), .grant_id(in_gid[0]),
    .r_wb(in_rwb[0]), .addr(in_addr[0]), .wdata(in_wdata[0]),
    .rdata_a(o_rd[0][0]), .rdata_b(o_rd[0][1]), .rdata_c(o_rd[0][2]),
    .rvalid_a(o_rv[0][0]), .rvalid_b(o_rv[0][1]), .rvalid_c(o_rv[0][2]),
    .wdone(o_wdone[0]), .busy(o_busy[0])
  );

  mem_responder #(.WAIT_STATES(2)) u_dut_ws2 (
    .clock(clock), .reset(reset), .sel(in_sel[1]), .grant_id(in_gid[1]),
    .r_wb(in_rwb[1]), .addr(in_addr[1]), .wdata(in_wdata[1]),
    .rdata_a(o_rd[1][0]), .rdata_b(o_rd[1][1]), .rdata_c(o_rd[1][2]),
    .rvalid_a(o_rv[1][0]), .rvalid_b(o_rv[1][1]), .rvalid_c(o_rv[1][2]),
    .wdone(o_wdone[1]), .busy(o_busy[1])
  );

  // Reference model: memory image per instance and last read value per master.
  logic [7:0] mem_m  [2][4096];
  bit         wr_m   [2][4096];
  logic [7:0] exp_rd [2][3];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rv_vec(input int k);
    return {o_rv[k][2], o_rv[k][1], o_rv[k][0]};
  endfunction

  task automatic check_rdata(input int k, input string tag);
    for (int p = 0; p < 3; p++)
      check($sformatf("%s d%0d rdata[%0d]", tag, k, p), 32'(o_rd[k][p]), 32'(exp_rd[k][p]));
  endtask

  task automatic quiet(input int k);
    in_sel[k] = 1'b0;
    in_gid[k] = 2'd0;
  endtask

  // One access: drive, accept on next edge, then check busy and strobes each
  // cycle until completion at accept + WAIT_STATES + 1. With scramble set the
  // inputs are disturbed while busy. Returns right after the completion
  // sample, so a following call is accepted back-to-back.
  task automatic access(input int k, input bit rwb, input logic [1:0] gid,
                        input logic [11:0] a, input logic [7:0] d,
                        input bit scramble, input string tag);
    int lat;
    logic [2:0] rv_exp;
    lat = (k == 0) ? 1 : 3;
    in_sel[k] = 1'b1; in_gid[k] = gid; in_rwb[k] = rwb;
    in_addr[k] = a; in_wdata[k] = d;
    @(posedge clock); #1;
    if (scramble) begin
      in_addr[k]  = 12'hFFF;
      in_wdata[k] = 8'hFF;
      in_gid[k]   = (gid == 2'd3) ? 2'd1 : gid + 2'd1;
    end else begin
      quiet(k);
    end
    rv_exp = 3'b000;
    if (!rwb) begin
      mem_m[k][a] = d;
      wr_m[k][a]  = 1'b1;
    end else begin
      exp_rd[k][int'(gid) - 1] = mem_m[k][a];
      rv_exp = 3'(1 << (int'(gid) - 1));
    end
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) begin @(posedge clock); #1; end
      if (i == lat) quiet(k);
      check($sformatf("%s d%0d busy@%0d", tag, k, i), 32'(o_busy[k]), 32'(i != lat));
      check($sformatf("%s d%0d wdone@%0d", tag, k, i), 32'(o_wdone[k]), 32'((i == lat) && !rwb));
      check($sformatf("%s d%0d rvalid@%0d", tag, k, i), 32'(rv_vec(k)), 32'((i == lat) ? rv_exp : 3'b000));
    end
    check_rdata(k, tag);
  endtask

  logic [11:0] pool [8];

  initial begin
    for (int k = 0; k < 2; k++) begin
      quiet(k);
      in_rwb[k] = 1'b0; in_addr[k] = '0; in_wdata[k] = '0;
      for (int p = 0; p < 3; p++) exp_rd[k][p] = 8'h00;
      for (int a = 0; a < 4096; a++) wr_m[k][a] = 1'b0;
    end

    // Reset state
    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst d%0d busy", k), 32'(o_busy[k]), 32'd0);
      check($sformatf("rst d%0d wdone", k), 32'(o_wdone[k]), 32'd0);
      check($sformatf("rst d%0d rvalid", k), 32'(rv_vec(k)), 32'd0);
      check_rdata(k, "rst");
    end
    reset = 1'b0;
    @(posedge clock); #1;

    // Write 0A5 <- 3C by A, then read by B; A and C outputs stay put
    access(1, 1'b0, 2'd1, 12'h0A5, 8'h3C, 1'b0, "wr0A5");
    access(1, 1'b1, 2'd2, 12'h0A5, 8'h00, 1'b0, "rd0A5");
    check("rd0A5 rdata_b", 32'(o_rd[1][1]), 32'h3C);

    // grant_id 0 is ignored
    in_sel[1] = 1'b1; in_gid[1] = 2'd0; in_rwb[1] = 1'b0;
    in_addr[1] = 12'h0A5; in_wdata[1] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("gid0 busy@%0d", i), 32'(o_busy[1]), 32'd0);
      check($sformatf("gid0 wdone@%0d", i), 32'(o_wdone[1]), 32'd0);
      check($sformatf("gid0 rvalid@%0d", i), 32'(rv_vec(1)), 32'd0);
    end
    quiet(1);
    access(1, 1'b1, 2'd3, 12'h0A5, 8'h00, 1'b0, "gid0rd");
    check("gid0 rdata_c", 32'(o_rd[1][2]), 32'h3C);

    // Inputs disturbed while busy: latched address/data are used
    access(1, 1'b0, 2'd1, 12'hFFF, 8'h5A, 1'b0, "wrFFF");
    access(1, 1'b0, 2'd2, 12'h123, 8'h96, 1'b1, "scr");
    access(1, 1'b1, 2'd1, 12'hFFF, 8'h00, 1'b0, "scrFFF");
    check("scr FFF kept", 32'(o_rd[1][0]), 32'h5A);
    access(1, 1'b1, 2'd3, 12'h123, 8'h00, 1'b0, "scr123");
    check("scr 123 written", 32'(o_rd[1][2]), 32'h96);

    // Reset in WAIT aborts a pending write
    access(1, 1'b0, 2'd1, 12'h010, 8'h11, 1'b0, "wr010");
    in_sel[1] = 1'b1; in_gid[1] = 2'd1; in_rwb[1] = 1'b0;
    in_addr[1] = 12'h010; in_wdata[1] = 8'h55;
    @(posedge clock); #1;
    quiet(1);
    @(posedge clock); #1;
    check("abort busy pre", 32'(o_busy[1]), 32'd1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 3; p++) exp_rd[k][p] = 8'h00;
    check("abort busy", 32'(o_busy[1]), 32'd0);
    check_rdata(1, "abort");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("abort wdone@%0d", i), 32'(o_wdone[1]), 32'd0);
      check($sformatf("abort rvalid@%0d", i), 32'(rv_vec(1)), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    access(1, 1'b1, 2'd3, 12'h010, 8'h00, 1'b0, "rd010");
    check("abort 010 prior", 32'(o_rd[1][2]), 32'h11);

    // Zero wait states, back-to-back write then read of FFF
    access(0, 1'b0, 2'd2, 12'hFFF, 8'hA7, 1'b0, "ws0wr");
    access(0, 1'b1, 2'd1, 12'hFFF, 8'h00, 1'b0, "ws0rd");
    check("ws0 rdata_a", 32'(o_rd[0][0]), 32'hA7);

    // Randomized accesses on both instances
    pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h0A5; pool[3] = 12'h800;
    for (int i = 4; i < 8; i++) pool[i] = 12'($urandom_range(0, 4095));
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [11:0] a;
      logic [1:0] g;
      bit rw;
      k  = n % 2;
      a  = pool[$urandom_range(0, 7)];
      g  = 2'($urandom_range(1, 3));
      rw = wr_m[k][a] ? 1'($urandom_range(0, 1)) : 1'b0;
      access(k, rw, g, a, 8'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
